// File: rtl/motor_pwm_if.sv
// Command/modulation inputs and PWM/H-bridge outputs of the motor PWM driver.
// master = command source (tracker side), slave = the driver itself.
interface motor_pwm_if;
  logic [2:0] state;
  logic [9:0] modulation_left;
  logic [9:0] modulation_right;
  logic       pwm_left;
  logic       pwm_right;
  logic [1:0] left_motor;
  logic [1:0] right_motor;
  logic [9:0] duty_left;
  logic [9:0] duty_right;

  modport master (
    output state, modulation_left, modulation_right,
    input  pwm_left, pwm_right, left_motor, right_motor, duty_left, duty_right
  );

  modport slave (
    input  state, modulation_left, modulation_right,
    output pwm_left, pwm_right, left_motor, right_motor, duty_left, duty_right
  );
endinterface

// File: rtl/motor_pwm_driver.sv
// Per-wheel PWM + H-bridge driver with period-aligned slew-limited duty and coast dead-time on reversal.
// Wheel FSM:  state | meaning
//             RUN   | pins follow direction, duty ramps toward target at each period boundary
//             DEAD  | pins 00, duty 0, counting down before a direction change takes effect
module motor_pwm_driver #(
  parameter int RAMP_STEP   = 64,
  parameter int DEAD_CYCLES = 2048,
  parameter int TURN_SPEED  = 600,
  parameter int SHARP_SPEED = 800
) (
  input  logic         clk,
  input  logic         reset,
  motor_pwm_if.slave   bus
);
  localparam int DW = $clog2(DEAD_CYCLES + 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DEAD = 1'b1;

  localparam logic [2:0] CMD_TURN_L  = 3'b000;
  localparam logic [2:0] CMD_TURN_R  = 3'b001;
  localparam logic [2:0] CMD_GO      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_SHARP_L = 3'b100;
  localparam logic [2:0] CMD_SHARP_R = 3'b101;

  localparam logic [1:0] PINS_FWD   = 2'b10;
  localparam logic [1:0] PINS_REV   = 2'b01;
  localparam logic [1:0] PINS_COAST = 2'b00;

  localparam logic [9:0]    STEP      = 10'(RAMP_STEP);
  localparam logic [9:0]    TURN_D    = 10'(TURN_SPEED);
  localparam logic [9:0]    SHARP_D   = 10'(SHARP_SPEED);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

  // index 0 = left wheel, 1 = right wheel; dir bit 1 = forward
  logic [2:0]            cmd_q;
  logic [1:0][9:0]       mod_q;
  logic [9:0]            cnt_q;
  logic [1:0][9:0]       duty_q, duty_d;
  logic [1:0]            dir_q, dir_d;
  logic [1:0][1:0]       pins_q, pins_d;
  logic [1:0][0:0]       fsm_q, fsm_d;
  logic [1:0][DW-1:0]    dead_q, dead_d;
  logic [1:0]            pwm_q;
  logic [1:0][9:0]       tgt_duty;
  logic [1:0]            tgt_dir;
  logic                  boundary;

  function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? a : b;
  endfunction

  // Saturating step toward tgt; the gap test keeps the result inside 0..1023.
  function automatic logic [9:0] ramp(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] gap;
    if (cur < tgt) begin
      gap = tgt - cur;
      return (gap > STEP) ? cur + STEP : tgt;
    end
    gap = cur - tgt;
    return (gap > STEP) ? cur - STEP : tgt;
  endfunction

  assign boundary = (cnt_q == 10'h3FF);

  always_comb begin
    tgt_duty = '0;
    tgt_dir  = dir_q;
    case (cmd_q)
      CMD_TURN_L: begin
        tgt_duty[0] = min10(TURN_D, mod_q[0]);
        tgt_duty[1] = mod_q[1];
        tgt_dir     = 2'b11;
      end
      CMD_TURN_R: begin
        tgt_duty[0] = mod_q[0];
        tgt_duty[1] = min10(TURN_D, mod_q[1]);
        tgt_dir     = 2'b11;
      end
      CMD_GO: begin
        tgt_duty = mod_q;
        tgt_dir  = 2'b11;
      end
      CMD_SHARP_L: begin
        tgt_duty[0] = SHARP_D;
        tgt_duty[1] = SHARP_D;
        tgt_dir     = 2'b10;
      end
      CMD_SHARP_R: begin
        tgt_duty[0] = SHARP_D;
        tgt_duty[1] = SHARP_D;
        tgt_dir     = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    duty_d = duty_q;
    dir_d  = dir_q;
    pins_d = pins_q;
    fsm_d  = fsm_q;
    dead_d = dead_q;
    for (int w = 0; w < 2; w++) begin
      case (fsm_q[w])
        ST_RUN: begin
          if ((tgt_dir[w] != dir_q[w]) && (tgt_duty[w] != '0)) begin
            duty_d[w] = '0;
            pins_d[w] = PINS_COAST;
            dead_d[w] = DEAD_LOAD;
            fsm_d[w]  = ST_DEAD;
          end else if (boundary) begin
            duty_d[w] = ramp(duty_q[w], tgt_duty[w]);
          end
        end
        default: begin
          // Direction is taken from the target at exit, so a command that
          // flipped back during the coast simply restores the old pins.
          if (dead_q[w] < DW'(2)) begin
            dir_d[w]  = tgt_dir[w];
            pins_d[w] = tgt_dir[w] ? PINS_FWD : PINS_REV;
            dead_d[w] = '0;
            fsm_d[w]  = ST_RUN;
          end else begin
            dead_d[w] = dead_q[w] - DW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q  <= CMD_STOP;
      mod_q  <= '0;
      cnt_q  <= '0;
      duty_q <= '0;
      dir_q  <= 2'b11;
      pins_q <= {PINS_FWD, PINS_FWD};
      fsm_q  <= {ST_RUN, ST_RUN};
      dead_q <= '0;
      pwm_q  <= '0;
    end else begin
      cmd_q    <= bus.state;
      mod_q    <= {bus.modulation_right, bus.modulation_left};
      cnt_q    <= cnt_q + 10'd1;
      duty_q   <= duty_d;
      dir_q    <= dir_d;
      pins_q   <= pins_d;
      fsm_q    <= fsm_d;
      dead_q   <= dead_d;
      pwm_q[0] <= (cnt_q < duty_q[0]);
      pwm_q[1] <= (cnt_q < duty_q[1]);
    end
  end

  assign bus.pwm_left    = pwm_q[0];
  assign bus.pwm_right   = pwm_q[1];
  assign bus.left_motor  = pins_q[0];
  assign bus.right_motor = pins_q[1];
  assign bus.duty_left   = duty_q[0];
  assign bus.duty_right  = duty_q[1];
endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: table-driven ramp phases plus hand-written
// reversal, dead-time, stop and async-reset sequences, checked through a scoreboard queue.
module tb_motor_pwm_driver;
  logic clk = 1'b0;
  logic reset;

  motor_pwm_if bus();

  motor_pwm_driver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmd;
    int mod_l, mod_r, tgt_l, tgt_r, periods;
    logic [1:0] pins_l, pins_r;
  } vec_t;

  typedef struct {
    int dl, dr, hl, hr;
    bit chk_pwm;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int ecnt = 0;
  int ml = 0, mr = 0;
  int hl = 0, hr = 0;

  function automatic int step(input int cur, input int tgt);
    if (cur < tgt) return (tgt - cur > 64) ? cur + 64 : tgt;
    if (cur > tgt) return (cur - tgt > 64) ? cur - 64 : tgt;
    return cur;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (bus.pwm_left === 1'b1) hl++;
    if (bus.pwm_right === 1'b1) hr++;
  endtask

  // Advance to just after the next PWM period boundary, counting pwm-high cycles.
  task automatic to_boundary();
    hl = 0;
    hr = 0;
    do tick(); while (ecnt % 1024 != 0);
  endtask

  task automatic drive_cmd(input logic [2:0] c, input int l, input int r);
    bus.state            = c;
    bus.modulation_left  = 10'(l);
    bus.modulation_right = 10'(r);
  endtask

  task automatic period_check(input int tl, input int tr, input bit chk_pwm, input string name);
    exp_t e;
    e.hl = ml;
    e.hr = mr;
    ml = step(ml, tl);
    mr = step(mr, tr);
    e.dl = ml;
    e.dr = mr;
    e.chk_pwm = chk_pwm;
    sb.push_back(e);
    to_boundary();
    e = sb.pop_front();
    chk({name, " duty_left"}, bus.duty_left, e.dl);
    chk({name, " duty_right"}, bus.duty_right, e.dr);
    if (e.chk_pwm) begin
      chk({name, " pwm_left_highs"}, hl, e.hl);
      chk({name, " pwm_right_highs"}, hr, e.hr);
    end
  endtask

  task automatic pins(input string name, input logic [1:0] l, input logic [1:0] r);
    chk({name, " left_motor"}, bus.left_motor, l);
    chk({name, " right_motor"}, bus.right_motor, r);
  endtask

  initial begin
    vecs[0] = '{3'b010, 1023, 1023, 1023, 1023, 17, 2'b10, 2'b10};
    vecs[1] = '{3'b000, 1023, 1023,  600, 1023,  8, 2'b10, 2'b10};
    vecs[2] = '{3'b010,  800,  800,  800,  800,  4, 2'b10, 2'b10};
    vecs[3] = '{3'b001,  900,  700,  900,  600,  4, 2'b10, 2'b10};
    vecs[4] = '{3'b010,  800,  800,  800,  800,  4, 2'b10, 2'b10};

    reset = 1'b0;
    drive_cmd(3'b011, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset duty_left", bus.duty_left, 0);
    chk("reset duty_right", bus.duty_right, 0);
    chk("reset pwm_left", bus.pwm_left, 0);
    chk("reset pwm_right", bus.pwm_right, 0);
    pins("reset", 2'b10, 2'b10);

    @(negedge clk);
    reset = 1'b1;
    ecnt = 0;

    for (int i = 0; i < 5; i++) begin
      drive_cmd(vecs[i].cmd, vecs[i].mod_l, vecs[i].mod_r);
      for (int p = 0; p < vecs[i].periods; p++)
        period_check(vecs[i].tgt_l, vecs[i].tgt_r, 1'b1, $sformatf("vec%0d.p%0d", i, p));
      pins($sformatf("vec%0d", i), vecs[i].pins_l, vecs[i].pins_r);
    end

    // Sharp left from forward 800: coast 2048 cycles, then reverse and ramp to 800.
    drive_cmd(3'b100, 800, 800);
    tick();
    tick();
    ml = 0;
    pins("sharp_l entry", 2'b00, 2'b10);
    chk("sharp_l entry duty_left", bus.duty_left, 0);
    chk("sharp_l entry duty_right", bus.duty_right, 800);
    repeat (2047) tick();
    pins("sharp_l last dead", 2'b00, 2'b10);
    tick();
    pins("sharp_l exit", 2'b01, 2'b10);
    chk("sharp_l exit duty_left", bus.duty_left, 0);
    for (int p = 0; p < 13; p++)
      period_check(800, 800, p != 0, $sformatf("sharp_l.p%0d", p));

    // Reversal toward forward, flipped back to reverse mid-coast: old pins restored, count kept.
    drive_cmd(3'b010, 800, 800);
    tick();
    tick();
    ml = 0;
    pins("flip entry", 2'b00, 2'b10);
    repeat (998) tick();
    drive_cmd(3'b100, 800, 800);
    repeat (1049) tick();
    pins("flip last dead", 2'b00, 2'b10);
    tick();
    pins("flip exit", 2'b01, 2'b10);
    period_check(800, 800, 1'b0, "flip ramp");

    // Stop never coasts: ramp down with pins held, pwm low once duty reaches 0.
    drive_cmd(3'b011, 800, 800);
    period_check(0, 0, 1'b1, "stop.p0");
    pins("stop.p0", 2'b01, 2'b10);
    period_check(0, 0, 1'b1, "stop.p1");
    pins("stop.p1", 2'b01, 2'b10);

    // Sharp right reverses both wheels; go_straight mid-coast: left takes new fwd, right restores fwd.
    drive_cmd(3'b101, 500, 500);
    tick();
    tick();
    ml = 0;
    mr = 0;
    pins("both entry", 2'b00, 2'b00);
    chk("both entry duty_right", bus.duty_right, 0);
    repeat (998) tick();
    drive_cmd(3'b010, 500, 500);
    repeat (1049) tick();
    pins("both last dead", 2'b00, 2'b00);
    tick();
    pins("both exit", 2'b10, 2'b10);
    period_check(500, 500, 1'b0, "both ramp.p0");
    period_check(500, 500, 1'b1, "both ramp.p1");

    // Asynchronous reset mid-ramp, sampled before any further clock edge.
    repeat (30) tick();
    chk("pre-reset pwm_left", bus.pwm_left, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset duty_left", bus.duty_left, 0);
    chk("async reset duty_right", bus.duty_right, 0);
    chk("async reset pwm_left", bus.pwm_left, 0);
    chk("async reset pwm_right", bus.pwm_right, 0);
    pins("async reset", 2'b10, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Actuator end of the line-follower path: consumes the 3-bit drive command from the tracker policy and the 10-bit per-wheel speed modulation from the curvature logic.
- Produces per-wheel PWM and H-bridge direction pins.
- Adds glitch-free period-aligned duty updates, slew-limited ramping, and a coast dead-time whenever a wheel reverses direction.
- Sits between the tracker/modulation blocks and the board motor-driver pins.

Parameters:
- RAMP_STEP, 64, max duty change per PWM period (ramp up and down).
- DEAD_CYCLES, 2048, clk cycles a wheel coasts (both pins 0) before a direction reversal.
- TURN_SPEED, 600, inner-wheel duty for gentle turns.
- SHARP_SPEED, 800, duty of both wheels during sharp (pivot) turns.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- state  in  3  command: 000 turn_left, 001 turn_right, 010 go_straight, 011 stop, 100 sharp_turn_left, 101 sharp_turn_right, 110/111 treated as stop
- modulation_left  in  10  left wheel speed ceiling (1023 = full)
- modulation_right  in  10  right wheel speed ceiling
- pwm_left  out  1  left enable PWM
- pwm_right  out  1  right enable PWM
- left_motor  out  2  {IN1,IN2}: 10 forward, 01 reverse, 00 coast
- right_motor  out  2  {IN3,IN4}, same encoding
- duty_left  out  10  currently applied left duty
- duty_right  out  10  currently applied right duty

Behaviour:
- Reset (reset=0, async):
  - PWM counter = 0.
  - Duties 0, pwm_* = 0.
  - *_motor = 10; internal direction = forward.
  - Wheel FSMs in RUN.
  - Input registers cleared to state=011 and modulation=0.
- Inputs are registered once per clk. All decisions use the registered copies (1 cycle latency).
- Target per command (dir, duty); mod_L/mod_R are the registered modulation values:
  - go_straight: L fwd mod_L; R fwd mod_R.
  - turn_left: L fwd min(TURN_SPEED, mod_L); R fwd mod_R.
  - turn_right: L fwd mod_L; R fwd min(TURN_SPEED, mod_R).
  - sharp_turn_left: L rev SHARP_SPEED; R fwd SHARP_SPEED.
  - sharp_turn_right: L fwd SHARP_SPEED; R rev SHARP_SPEED.
  - stop/110/111: target duty 0, direction unchanged.
- PWM counter:
  - 10-bit free-running, wraps 1023 -> 0.
  - pwm_x = (cnt < duty_x), registered. Duty 0 gives a constant low output; duty 1023 gives 1023/1024 high.
  - Period boundary = cycle where cnt==1023. Duty registers change only on a boundary, or when forced to 0 by a reversal.
- Per-wheel FSM, independent for each wheel:
  - RUN:
    - At each boundary, if target dir == current dir: duty moves toward target by at most RAMP_STEP, saturating exactly at target with no overshoot and no 10-bit wrap.
    - If target dir != current dir and target duty > 0: duty := 0, motor pins := 00 in the same cycle, load dead counter = DEAD_CYCLES, go to DEAD. This check happens every cycle, not only at the boundary.
  - DEAD:
    - Counter decrements each clk. Pins stay 00 and duty stays 0.
    - At 0: latch new direction, drive pins to its encoding, go to RUN. Ramp restarts from 0.
  - Target changes while in DEAD: the direction is re-evaluated at exit. If the target direction equals the old direction again, exit restores the old pins; the count is not restarted.
- A stop command never triggers dead-time. The wheel ramps down with its pins unchanged.
- Modulation changes mid-ramp retarget immediately; the ramp continues from the current duty.
- Reset asserted mid-ramp or mid-dead-time returns to reset values immediately.

Test Plan:
- Reset, then go_straight with mod 1023/1023 -> duty_left/right rise 0,64,128,… one step per 1024 clk and saturate at 1023 after 16 periods; pins 10/10; pwm high 1023 of 1024 cycles.
- At steady 1023, turn_left with mod_L=1023 -> duty_left ramps down by 64 per period to 600 and holds; duty_right stays at 1023.
- From forward at 800, sharp_turn_left -> next cycle left_motor=00, duty_left=0; after 2048 clk left_motor=01; duty then ramps 0->800. Right wheel is unaffected.
- Mid dead-time, command back to go_straight -> at dead-time expiry left_motor=10 and duty ramps toward mod_L.
- Stop with duty 1023 -> duty steps down 64/period to 0 with pins held at 10; pwm is constant low once duty is 0.
- Assert reset during a ramp or dead-time -> outputs are immediately 0 / 10 / 0 without waiting for a clk edge.
